reg_write_scheduler: RTL and testbench
======================================

// Module: reg_write_scheduler
// PURPOSE
// - Owns the single write port of the 32x32 register file in the RV32IM pipeline.
// - Arbitrates that port between pipeline writeback (WB) and the multi-cycle MUL/DIV unit (MD).
// - Keeps a busy scoreboard of registers awaiting MD results and raises hazard flags for decode.
// - Sequences register-file clearing after reset. The register-file reset is synchronous, so it is driven for INIT_CYCLES clocks.
// PARAMETERS
// - STARVE_LIMIT  4  consecutive cycles MD may be denied before MD takes priority
// - CNT_W         3  starvation counter width; must satisfy 2^CNT_W > STARVE_LIMIT
// - INIT_CYCLES   1  clocks RF_RESET is held after RESET deasserts (>=1)
// PORTS
// - CLK           in   1   clock, posedge
// - RESET         in   1   asynchronous, active-high reset
// - WB_REQ        in   1   writeback requests the write port this cycle
// - WB_ADDR       in   5   writeback destination register
// - WB_DATA       in   32  writeback data
// - WB_GNT        out  1   WB write accepted this cycle; WB_REQ & !WB_GNT stalls the pipeline
// - MD_ISSUE      in   1   MD op issued this cycle; marks MD_ISSUE_ADDR busy
// - MD_ISSUE_ADDR in   5   MD destination register
// - MD_REQ        in   1   MD result ready; held until MD_GNT
// - MD_ADDR       in   5   MD result destination
// - MD_DATA       in   32  MD result data
// - MD_GNT        out  1   MD write accepted this cycle
// - RS1ADDR       in   5   decode source 1
// - RS2ADDR       in   5   decode source 2
// - HAZ1          out  1   RS1ADDR busy in scoreboard
// - HAZ2          out  1   RS2ADDR busy in scoreboard
// - RF_IN         out  32  to register file IN
// - RF_INADDRESS  out  5   to register file INADDRESS
// - RF_WRITE      out  1   to register file WRITE
// - RF_RESET      out  1   to register file RESET
// - WAW_ERR       out  1   sticky: WB wrote a register still busy for MD
// - READY         out  1   init done, arbiter running
// BEHAVIOUR
// - Reset values: state=S_INIT, init count=0, scoreboard=0, starve count=0, WAW_ERR=0.
//   During reset RF_RESET=1. READY, WB_GNT, MD_GNT and RF_WRITE are 0.
// - FSM S_INIT: RF_RESET=1 and no grants. After INIT_CYCLES posedges, move to S_RUN.
// - FSM S_RUN: READY=1 and RF_RESET=0. S_RUN is held until RESET.
// - RESET asserted mid-operation: immediate return to S_INIT and all state cleared. Pending MD results are lost; MD must be reset too.
// - Arbitration is combinational, giving zero latency: the grant and the write happen at the same posedge.
// - WB wins by default. MD wins when only MD requests, or when starve count == STARVE_LIMIT.
// - Exactly one grant per cycle. The loser holds its REQ.
// - RF_IN, RF_INADDRESS and RF_WRITE mux from the granted requester. RF_WRITE=0 when there is no grant.
// - Address 0: the request is granted but RF_WRITE is forced 0. x0 is never marked busy.
// - Starve count: +1 per cycle with MD_REQ & !MD_GNT, saturating at STARVE_LIMIT. It clears on MD_GNT or !MD_REQ.
// - Scoreboard busy[a]: set at the posedge when MD_ISSUE & a==MD_ISSUE_ADDR & a!=0. Cleared at the posedge when MD_GNT & a==MD_ADDR.
//   If set and clear hit the same address in the same cycle, set wins (a new op is outstanding).
// - HAZ1/HAZ2 = busy[RSx]. They are combinational from current state, so a clear is visible the cycle after MD_GNT.
// - WAW_ERR sets when WB_GNT & busy[WB_ADDR]. The write still occurs and busy is unchanged. Only RESET clears WAW_ERR.
// CONFIGURATION
// - Macro REG_SCHED_BYPASS_EN, when defined, adds outputs BYP1_HIT, BYP2_HIT (1 bit) and BYP1_DATA, BYP2_DATA (32 bit).
//   BYPx_HIT = RF_WRITE & RF_INADDRESS==RSx, with BYPx_DATA=RF_IN. This forwards same-cycle write data to decode.
// - When the macro is undefined, these ports do not exist. Decode must then wait one cycle after a write to the same register.
// TESTING
// - Reset then release with INIT_CYCLES=1: expect RF_RESET=1 during reset and one cycle after, READY=1 from cycle 2, no grants before READY.
// - WB_REQ and MD_REQ held together, x5/x6: WB_GNT for 4 cycles, then MD_GNT on the 5th, and RF_INADDRESS=6 that cycle.
// - MD_ISSUE x7: HAZ1=1 for RS1ADDR=7. MD_GNT x7 with data 0xDEADBEEF: RF writes it, then HAZ1=0 the next cycle.
// - WB_REQ x0 data 0x1234: WB_GNT=1, RF_WRITE=0. MD_ISSUE x0: HAZ1 stays 0 for RS1ADDR=0.
// - MD_ISSUE x9 and MD_GNT x9 in the same cycle: busy[9] remains 1. Then WB write to x9: WAW_ERR=1 and sticky.
// - RESET pulse while busy[3]=1 and MD_REQ pending: scoreboard clears, READY=0, and S_INIT is re-run.

Source files
------------

// File: rtl/reg_write_scheduler_if.sv
// reg_write_scheduler_if: WB, MD, decode and register-file signals of the write scheduler.
// Bypass signals exist only when REG_SCHED_BYPASS_EN is defined.
interface reg_write_scheduler_if;
    logic        WB_REQ;
    logic [4:0]  WB_ADDR;
    logic [31:0] WB_DATA;
    logic        WB_GNT;
    logic        MD_ISSUE;
    logic [4:0]  MD_ISSUE_ADDR;
    logic        MD_REQ;
    logic [4:0]  MD_ADDR;
    logic [31:0] MD_DATA;
    logic        MD_GNT;
    logic [4:0]  RS1ADDR;
    logic [4:0]  RS2ADDR;
    logic        HAZ1;
    logic        HAZ2;
    logic [31:0] RF_IN;
    logic [4:0]  RF_INADDRESS;
    logic        RF_WRITE;
    logic        RF_RESET;
    logic        WAW_ERR;
    logic        READY;
`ifdef REG_SCHED_BYPASS_EN
    logic        BYP1_HIT;
    logic        BYP2_HIT;
    logic [31:0] BYP1_DATA;
    logic [31:0] BYP2_DATA;
`endif
    modport slave (
        input  WB_REQ, WB_ADDR, WB_DATA, MD_ISSUE, MD_ISSUE_ADDR, MD_REQ, MD_ADDR, MD_DATA,
               RS1ADDR, RS2ADDR,
`ifdef REG_SCHED_BYPASS_EN
        output BYP1_HIT, BYP2_HIT, BYP1_DATA, BYP2_DATA,
`endif
        output WB_GNT, MD_GNT, HAZ1, HAZ2, RF_IN, RF_INADDRESS, RF_WRITE, RF_RESET, WAW_ERR, READY
    );
    modport master (
        output WB_REQ, WB_ADDR, WB_DATA, MD_ISSUE, MD_ISSUE_ADDR, MD_REQ, MD_ADDR, MD_DATA,
               RS1ADDR, RS2ADDR,
`ifdef REG_SCHED_BYPASS_EN
        input  BYP1_HIT, BYP2_HIT, BYP1_DATA, BYP2_DATA,
`endif
        input  WB_GNT, MD_GNT, HAZ1, HAZ2, RF_IN, RF_INADDRESS, RF_WRITE, RF_RESET, WAW_ERR, READY
    );
endinterface

// File: rtl/reg_write_scheduler.sv
// reg_write_scheduler: register-file write-port arbiter (WB vs MUL/DIV), busy scoreboard and RF init.
// Optional same-cycle forwarding to decode is enabled by defining REG_SCHED_BYPASS_EN.
module reg_write_scheduler #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3,
    parameter int INIT_CYCLES  = 1
) (
    input logic CLK,
    input logic RESET,
    reg_write_scheduler_if.slave bus
);
    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    typedef enum logic {S_INIT, S_RUN} state_t;
    state_t           state;
    logic [IW-1:0]    init_cnt;
    logic             ready, rf_reset, waw_err;
    logic [CNT_W-1:0] starve;
    logic [31:0]      busy, set_mask, clr_mask;
    logic             md_pri, wb_gnt, md_gnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= S_INIT;
            init_cnt <= '0;
            ready    <= 1'b0;
            rf_reset <= 1'b1;
        end else if (state == S_INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == IW'(INIT_CYCLES - 1)) begin
                state    <= S_RUN;
                ready    <= 1'b1;
                rf_reset <= 1'b0;
            end
        end
    end

    // MD wins when WB is idle or MD has been denied STARVE_LIMIT cycles in a row
    always_comb begin
        md_pri   = bus.MD_REQ & (!bus.WB_REQ | (starve == CNT_W'(STARVE_LIMIT)));
        wb_gnt   = ready & bus.WB_REQ & !md_pri;
        md_gnt   = ready & md_pri;
        set_mask = (bus.MD_ISSUE && bus.MD_ISSUE_ADDR != 5'd0) ? 32'd1 << bus.MD_ISSUE_ADDR : 32'd0;
        clr_mask = md_gnt ? 32'd1 << bus.MD_ADDR : 32'd0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            busy    <= '0;
            starve  <= '0;
            waw_err <= 1'b0;
        end else begin
            busy    <= (busy & ~clr_mask) | set_mask;
            waw_err <= waw_err | (wb_gnt & busy[bus.WB_ADDR]);
            starve  <= (!bus.MD_REQ || md_gnt) ? '0 :
                       (starve == CNT_W'(STARVE_LIMIT)) ? starve : starve + 1'b1;
        end
    end

    assign bus.WB_GNT       = wb_gnt;
    assign bus.MD_GNT       = md_gnt;
    assign bus.RF_IN        = md_gnt ? bus.MD_DATA : bus.WB_DATA;
    assign bus.RF_INADDRESS = md_gnt ? bus.MD_ADDR : bus.WB_ADDR;
    assign bus.RF_WRITE     = (wb_gnt | md_gnt) & (bus.RF_INADDRESS != 5'd0);
    assign bus.RF_RESET     = rf_reset;
    assign bus.READY        = ready;
    assign bus.WAW_ERR      = waw_err;
    assign bus.HAZ1         = busy[bus.RS1ADDR];
    assign bus.HAZ2         = busy[bus.RS2ADDR];
`ifdef REG_SCHED_BYPASS_EN
    assign bus.BYP1_HIT     = bus.RF_WRITE & (bus.RF_INADDRESS == bus.RS1ADDR);
    assign bus.BYP2_HIT     = bus.RF_WRITE & (bus.RF_INADDRESS == bus.RS2ADDR);
    assign bus.BYP1_DATA    = bus.RF_IN;
    assign bus.BYP2_DATA    = bus.RF_IN;
`endif
endmodule

// File: tb/tb_reg_write_scheduler.sv
// tb_reg_write_scheduler: directed per-cycle vector table plus hand-written reset/init sequences.
module tb_reg_write_scheduler;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   compared = 0;
    int   mismatched = 0;

    reg_write_scheduler_if bus();
    reg_write_scheduler dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    always #5 CLK = ~CLK;

    typedef struct {
        logic        wr; logic [4:0] wa; logic [31:0] wd;
        logic        mr; logic [4:0] ma; logic [31:0] md;
        logic        mi; logic [4:0] mia;
        logic [4:0]  r1; logic [4:0] r2;
        logic        ewg; logic emg; logic erw; logic [4:0] ea; logic [31:0] ed;
        logic        eh1; logic eh2; logic ew;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mr, input logic [4:0] ma, input logic [31:0] md,
                       input logic mi, input logic [4:0] mia, input logic [4:0] r1, input logic [4:0] r2,
                       input logic ewg, input logic emg, input logic erw, input logic [4:0] ea,
                       input logic [31:0] ed, input logic eh1, input logic eh2, input logic ew);
        vec_t v;
        v = '{wr, wa, wd, mr, ma, md, mi, mia, r1, r2, ewg, emg, erw, ea, ed, eh1, eh2, ew};
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.WB_REQ = v.wr; bus.WB_ADDR = v.wa; bus.WB_DATA = v.wd;
        bus.MD_REQ = v.mr; bus.MD_ADDR = v.ma; bus.MD_DATA = v.md;
        bus.MD_ISSUE = v.mi; bus.MD_ISSUE_ADDR = v.mia;
        bus.RS1ADDR = v.r1; bus.RS2ADDR = v.r2;
    endtask

    initial begin
        //  wr wa wd            mr ma md            mi mia r1 r2   ewg emg erw ea ed            eh1 eh2 ew
        for (int i = 0; i < 4; i++)
            add(1, 5, 32'hAAAA0005, 1, 6, 32'hBBBB0006, 0, 0, 0, 0, 1, 0, 1, 5, 32'hAAAA0005, 0, 0, 0);
        add(1, 5, 32'hAAAA0005, 1, 6, 32'hBBBB0006, 0, 0, 0, 0,   0, 1, 1, 6, 32'hBBBB0006, 0, 0, 0);
        add(1, 5, 32'h55, 0, 0, 0, 0, 0, 0, 0,                     1, 0, 1, 5, 32'h55, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 7, 7, 0,                          0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 7, 7,                          0, 0, 0, 0, 0, 1, 1, 0);
        add(0, 0, 0, 1, 7, 32'hDEADBEEF, 0, 0, 7, 0,               0, 1, 1, 7, 32'hDEADBEEF, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 7, 7,                          0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0,                   1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0,                          0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                          0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 9, 0, 0,                          0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 9, 32'hC0C0C0C0, 1, 9, 9, 0,               0, 1, 1, 9, 32'hC0C0C0C0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 9, 9,                          0, 0, 0, 0, 0, 1, 1, 0);
        add(1, 9, 32'hD0D0D0D0, 0, 0, 0, 0, 0, 9, 0,               1, 0, 1, 9, 32'hD0D0D0D0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 9, 0,                          0, 0, 0, 0, 0, 1, 0, 1);
        add(1, 4, 32'h44, 0, 0, 0, 0, 0, 0, 9,                     1, 0, 1, 4, 32'h44, 0, 1, 1);
        add(0, 0, 0, 1, 0, 32'h99, 0, 0, 0, 0,                     0, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 2; i++)
            add(1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 0, 0,            1, 0, 1, 1, 32'h11, 0, 0, 1);
        add(1, 1, 32'h11, 0, 2, 32'h22, 0, 0, 0, 0,                1, 0, 1, 1, 32'h11, 0, 0, 1);
        for (int i = 0; i < 4; i++)
            add(1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 0, 0,            1, 0, 1, 1, 32'h11, 0, 0, 1);
        add(1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 0, 0,                0, 1, 1, 2, 32'h22, 0, 0, 1);

        drive('{1, 5, 32'h5, 1, 6, 32'h6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_rf_reset", 0, 32'(bus.RF_RESET), 1);
        chk("rst_ready", 0, 32'(bus.READY), 0);
        chk("rst_wb_gnt", 0, 32'(bus.WB_GNT), 0);
        chk("rst_md_gnt", 0, 32'(bus.MD_GNT), 0);
        chk("rst_rf_write", 0, 32'(bus.RF_WRITE), 0);
        chk("rst_waw", 0, 32'(bus.WAW_ERR), 0);
        RESET = 1'b0;
        bus.MD_REQ = 1'b0;
        #1;
        chk("init_rf_reset", 0, 32'(bus.RF_RESET), 1);
        chk("init_ready", 0, 32'(bus.READY), 0);
        chk("init_wb_gnt", 0, 32'(bus.WB_GNT), 0);
        @(negedge CLK);
        #1;
        chk("run_ready", 0, 32'(bus.READY), 1);
        chk("run_rf_reset", 0, 32'(bus.RF_RESET), 0);
        chk("run_wb_gnt", 0, 32'(bus.WB_GNT), 1);
        bus.WB_REQ = 1'b0;

        foreach (vecs[i]) begin
            @(negedge CLK);
            drive(vecs[i]);
            #1;
            chk("wb_gnt", i, 32'(bus.WB_GNT), 32'(vecs[i].ewg));
            chk("md_gnt", i, 32'(bus.MD_GNT), 32'(vecs[i].emg));
            chk("rf_write", i, 32'(bus.RF_WRITE), 32'(vecs[i].erw));
            chk("haz1", i, 32'(bus.HAZ1), 32'(vecs[i].eh1));
            chk("haz2", i, 32'(bus.HAZ2), 32'(vecs[i].eh2));
            chk("waw_err", i, 32'(bus.WAW_ERR), 32'(vecs[i].ew));
            if (vecs[i].erw) begin
                chk("rf_addr", i, 32'(bus.RF_INADDRESS), 32'(vecs[i].ea));
                chk("rf_in", i, bus.RF_IN, vecs[i].ed);
            end
        end

        @(negedge CLK);
        drive('{0, 0, 0, 0, 0, 0, 1, 3, 3, 9, 0, 0, 0, 0, 0, 0, 0, 0});
        @(negedge CLK);
        drive('{1, 1, 32'h11, 1, 3, 32'h33, 0, 0, 3, 9, 0, 0, 0, 0, 0, 0, 0, 0});
        #1;
        chk("pre_rst_haz1", 0, 32'(bus.HAZ1), 1);
        chk("pre_rst_haz2", 0, 32'(bus.HAZ2), 1);
        chk("pre_rst_wb_gnt", 0, 32'(bus.WB_GNT), 1);
        RESET = 1'b1;
        #1;
        chk("mid_rst_ready", 0, 32'(bus.READY), 0);
        chk("mid_rst_rf_reset", 0, 32'(bus.RF_RESET), 1);
        chk("mid_rst_haz1", 0, 32'(bus.HAZ1), 0);
        chk("mid_rst_haz2", 0, 32'(bus.HAZ2), 0);
        chk("mid_rst_waw", 0, 32'(bus.WAW_ERR), 0);
        chk("mid_rst_gnt", 0, 32'({bus.WB_GNT, bus.MD_GNT, bus.RF_WRITE}), 0);
        @(negedge CLK);
        RESET = 1'b0;
        bus.MD_REQ = 1'b0;
        #1;
        chk("reinit_ready", 0, 32'(bus.READY), 0);
        chk("reinit_rf_reset", 0, 32'(bus.RF_RESET), 1);
        chk("reinit_wb_gnt", 0, 32'(bus.WB_GNT), 0);
        @(negedge CLK);
        #1;
        chk("rerun_ready", 0, 32'(bus.READY), 1);
        chk("rerun_rf_reset", 0, 32'(bus.RF_RESET), 0);
        chk("rerun_wb_gnt", 0, 32'(bus.WB_GNT), 1);
        chk("rerun_rf_addr", 0, 32'(bus.RF_INADDRESS), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
